// File: rtl/obstacle_field.sv
// Falling-obstacle field for the VGA dodge game: spawns squares at pseudo-random columns,
// drops them once per frame, scores exits, detects player collisions and drives the obstacle pixel mask.
module obstacle_field #(
  parameter int         N_OBS        = 4,
  parameter int         OBS_SIZE     = 32,
  parameter int         PLAYER_W     = 32,
  parameter int         PLAYER_H     = 32,
  parameter int         SPAWN_PERIOD = 60,
  parameter int         STEP         = 2,
  parameter int         SCREEN_W     = 640,
  parameter int         SCREEN_H     = 480,
  parameter logic [9:0] LFSR_SEED    = 10'h2A5
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       vsync,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic       obstacle_drawing,
  output logic       game_over,
  output logic [6:0] score,
  output logic [6:0] max_score
);

  // state | meaning
  // IDLE  | waiting for start key (active-low)
  // PLAY  | obstacles fall, spawn timer runs, collisions checked
  // OVER  | field frozen until start key released
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam int TW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [9:0] SPAWN_LIM = 10'(SCREEN_W - OBS_SIZE);

  logic [1:0]       r_state;
  logic             r_vs_meta, r_vs_sync, r_vs_d;
  logic [9:0]       r_lfsr;
  logic [TW-1:0]    r_timer;
  logic [N_OBS-1:0] r_active;
  logic [9:0]       r_x [N_OBS];
  logic [9:0]       r_y [N_OBS];
  logic [6:0]       r_score, r_max;
  logic             r_draw;

  logic             w_frame_tick, w_tick_play, w_spawn_now;
  logic [9:0]       w_spawn_x;
  logic [N_OBS-1:0] w_spawn_mask;
  logic [N_OBS-1:0] w_exit;
  logic [10:0]      w_y_next [N_OBS];
  logic [7:0]       w_score_sum;
  logic [6:0]       w_score_next;
  logic             w_collide, w_pix_hit, w_pix_on_screen;

  assign w_frame_tick = r_vs_d & ~r_vs_sync;
  assign w_tick_play  = w_frame_tick && (r_state == S_PLAY);
  assign w_spawn_now  = w_tick_play && (r_timer == TW'(SPAWN_PERIOD - 1));
  assign w_spawn_x    = (r_lfsr < SPAWN_LIM) ? r_lfsr : r_lfsr - SPAWN_LIM;
  // lowest clear bit of r_active as a one-hot; zero when every slot is busy
  assign w_spawn_mask = w_spawn_now ? (~r_active & (r_active + 1'b1)) : '0;
  assign w_score_next = (w_score_sum > 8'd127) ? 7'd127 : w_score_sum[6:0];
  assign w_pix_on_screen = ({1'b0, next_x} < 11'(SCREEN_W)) && ({1'b0, next_y} < 11'(SCREEN_H));

  always_comb begin
    w_collide   = 1'b0;
    w_pix_hit   = 1'b0;
    w_exit      = '0;
    w_score_sum = {1'b0, r_score};
    for (int i = 0; i < N_OBS; i++) begin
      w_y_next[i] = {1'b0, r_y[i]} + 11'(STEP);
      w_exit[i]   = w_tick_play && r_active[i] && (w_y_next[i] >= 11'(SCREEN_H));
      w_score_sum = w_score_sum + {7'd0, w_exit[i]};
      if (r_active[i]
          && ({1'b0, r_x[i]} < {1'b0, player_x} + 11'(PLAYER_W))
          && ({1'b0, player_x} < {1'b0, r_x[i]} + 11'(OBS_SIZE))
          && ({1'b0, r_y[i]} < {1'b0, player_y} + 11'(PLAYER_H))
          && ({1'b0, player_y} < {1'b0, r_y[i]} + 11'(OBS_SIZE)))
        w_collide = 1'b1;
      if (r_active[i]
          && (next_x >= r_x[i]) && ({1'b0, next_x} < {1'b0, r_x[i]} + 11'(OBS_SIZE))
          && (next_y >= r_y[i]) && ({1'b0, next_y} < {1'b0, r_y[i]} + 11'(OBS_SIZE)))
        w_pix_hit = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_vs_meta <= 1'b1;
      r_vs_sync <= 1'b1;
      r_vs_d    <= 1'b1;
      r_lfsr    <= LFSR_SEED;
      r_timer   <= '0;
      r_active  <= '0;
      r_score   <= '0;
      r_max     <= '0;
      r_draw    <= 1'b0;
      for (int i = 0; i < N_OBS; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      r_vs_meta <= vsync;
      r_vs_sync <= r_vs_meta;
      r_vs_d    <= r_vs_sync;
      r_lfsr    <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
      r_draw    <= (r_state != S_IDLE) && w_pix_hit && w_pix_on_screen;
      if (r_score > r_max)
        r_max <= r_score;
      case (r_state)
        S_IDLE: begin
          if (!start) begin
            r_state  <= S_PLAY;
            r_active <= '0;
            r_score  <= '0;
            r_timer  <= '0;
          end
        end
        S_PLAY: begin
          if (w_collide)
            r_state <= S_OVER;
          if (w_frame_tick) begin
            r_timer <= w_spawn_now ? '0 : r_timer + 1'b1;
            r_score <= w_score_next;
            for (int i = 0; i < N_OBS; i++) begin
              if (w_spawn_mask[i]) begin
                r_active[i] <= 1'b1;
                r_x[i]      <= w_spawn_x;
                r_y[i]      <= '0;
              end else if (r_active[i]) begin
                r_y[i] <= w_y_next[i][9:0];
                if (w_exit[i])
                  r_active[i] <= 1'b0;
              end
            end
          end
        end
        S_OVER: begin
          if (start)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign obstacle_drawing = r_draw;
  assign game_over        = (r_state != S_PLAY);
  assign score            = r_score;
  assign max_score        = r_max;

endmodule

// File: tb/tb_obstacle_field.sv
// Directed bench: default-parameter field (u_a) for play/exit/collision, and a fast-spawn field (u_b)
// for slot exhaustion, slot reuse and mid-game reset.
module tb_obstacle_field;

  logic       CLOCK_50;
  logic       reset;
  logic       vsync;
  logic [9:0] next_x, next_y;
  logic       start_a, start_b;
  logic [9:0] pxa, pya, pxb, pyb;
  logic       draw_a, draw_b, go_a, go_b;
  logic [6:0] score_a, score_b, max_a, max_b;

  logic [9:0] m_lfsr;
  int         cap_sx;
  int         sx0, sx1, sx260;
  int         n_total = 0;
  int         n_bad   = 0;

  obstacle_field u_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start_a), .vsync(vsync),
    .next_x(next_x), .next_y(next_y), .player_x(pxa), .player_y(pya),
    .obstacle_drawing(draw_a), .game_over(go_a), .score(score_a), .max_score(max_a)
  );

  obstacle_field #(.SPAWN_PERIOD(10)) u_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start_b), .vsync(vsync),
    .next_x(next_x), .next_y(next_y), .player_x(pxb), .player_y(pyb),
    .obstacle_drawing(draw_b), .game_over(go_b), .score(score_b), .max_score(max_b)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  // reference LFSR: x^10 + x^7 + 1, advancing every cycle out of reset
  always @(posedge CLOCK_50) begin
    if (reset) m_lfsr <= 10'h2A5;
    else       m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  function automatic int spawn_of(input logic [9:0] l);
    return (l < 10'd608) ? int'(l) : int'(l) - 608;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one vsync fall; returns on the negedge just after the edge that consumes frame_tick,
  // with cap_sx holding the column a spawn on that tick would use
  task automatic frame();
    repeat (3) @(negedge CLOCK_50);
    vsync = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    cap_sx = spawn_of(m_lfsr);
    @(negedge CLOCK_50);
    vsync = 1'b1;
  endtask

  task automatic probe_a(input string tag, input int x, input int y, input int exp);
    @(negedge CLOCK_50);
    next_x = 10'(x);
    next_y = 10'(y);
    @(negedge CLOCK_50);
    chk(tag, int'(draw_a), exp);
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b1; start_a = 1'b1; start_b = 1'b1;
    next_x = '0; next_y = '0;
    pxa = 10'd0; pya = 10'd448; pxb = 10'd1000; pyb = 10'd1000;
    sx0 = 0; sx1 = 0; sx260 = 0; cap_sx = 0;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;

    repeat (100) @(negedge CLOCK_50);
    chk("idle_game_over", int'(go_a), 1);
    chk("idle_score", int'(score_a), 0);
    chk("idle_max", int'(max_a), 0);
    probe_a("idle_draw_00", 0, 0, 0);
    probe_a("idle_draw_mid", 320, 240, 0);

    start_a = 1'b0;
    @(negedge CLOCK_50);
    chk("play_game_over", int'(go_a), 0);
    chk("play_score", int'(score_a), 0);

    for (int t = 1; t <= 339; t++) begin
      frame();
      if (t == 59) chk("pre_spawn_active", int'(u_a.r_active), 0);
      if (t == 60) begin
        sx0 = cap_sx;
        chk("spawn0_active", int'(u_a.r_active), 1);
        chk("spawn0_x", int'(u_a.r_x[0]), sx0);
        probe_a("draw_in", sx0 + 5, 3, 1);
        probe_a("draw_below", sx0 + 5, 40, 0);
        probe_a("draw_corner", sx0 + 31, 31, 1);
        probe_a("draw_right_edge", sx0 + 32, 5, 0);
        probe_a("draw_bottom_edge", sx0 + 5, 32, 0);
        pxa = 10'd1000;
      end
      if (t == 120) sx1 = cap_sx;
      if (t == 299) begin
        chk("pre_exit_active0", int'(u_a.r_active[0]), 1);
        chk("pre_exit_score", int'(score_a), 0);
      end
      if (t == 300) begin
        chk("exit_active0", int'(u_a.r_active[0]), 0);
        chk("exit_score", int'(score_a), 1);
        chk("exit_max_lag", int'(max_a), 0);
        @(negedge CLOCK_50);
        chk("exit_max", int'(max_a), 1);
        pxa = 10'(sx1);
        pya = 10'd448;
      end
      if (t == 328) begin
        chk("pre_hit_y", int'(u_a.r_y[1]), 416);
        chk("pre_hit_go", int'(go_a), 0);
      end
      if (t == 329) begin
        chk("hit_y", int'(u_a.r_y[1]), 418);
        chk("hit_go_same", int'(go_a), 0);
        @(negedge CLOCK_50);
        chk("hit_go_next", int'(go_a), 1);
        probe_a("over_draw_top", sx1 + 5, 418, 1);
        probe_a("over_draw_above", sx1 + 5, 417, 0);
      end
    end
    chk("frozen_y", int'(u_a.r_y[1]), 418);
    chk("frozen_score", int'(score_a), 1);
    chk("frozen_go", int'(go_a), 1);
    probe_a("frozen_draw", sx1 + 5, 418, 1);
    probe_a("offscreen_x", 700, 418, 0);

    start_b = 1'b0;
    @(negedge CLOCK_50);
    chk("b_play", int'(go_b), 0);
    for (int t = 1; t <= 500; t++) begin
      frame();
      if (t == 39) chk("b_t39_active", int'(u_b.r_active), 4'b0111);
      if (t == 40) chk("b_t40_active", int'(u_b.r_active), 4'b1111);
      if (t == 50) begin
        chk("b_t50_active", int'(u_b.r_active), 4'b1111);
        chk("b_t50_y0", int'(u_b.r_y[0]), 80);
      end
      if (t == 250) begin
        chk("b_t250_active", int'(u_b.r_active), 4'b1110);
        chk("b_t250_score", int'(score_b), 1);
      end
      if (t == 260) begin
        sx260 = cap_sx;
        chk("b_reuse_active", int'(u_b.r_active), 4'b1101);
        chk("b_reuse_y0", int'(u_b.r_y[0]), 0);
        chk("b_reuse_x0", int'(u_b.r_x[0]), sx260);
        chk("b_t260_score", int'(score_b), 2);
      end
      if (t == 280) begin
        chk("b_t280_active", int'(u_b.r_active), 4'b0111);
        chk("b_t280_score", int'(score_b), 4);
      end
    end
    chk("b_t500_score", int'(score_b), 5);
    chk("b_t500_active", int'(u_b.r_active), 4'b1110);
    @(negedge CLOCK_50);
    chk("b_t500_max", int'(max_b), 5);
    chk("b_still_play", int'(go_b), 0);

    reset = 1'b1;
    @(negedge CLOCK_50);
    chk("rst_score", int'(score_b), 0);
    chk("rst_max", int'(max_b), 0);
    chk("rst_active", int'(u_b.r_active), 0);
    chk("rst_go", int'(go_b), 1);
    chk("rst_max_a", int'(max_a), 0);
    chk("rst_go_a", int'(go_a), 1);
    @(negedge CLOCK_50);
    chk("rst_draw_a", int'(draw_a), 0);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/obstacle_field.md
OBSTACLE_FIELD -- requirements
Module: obstacle_field

Interface
REQ-001 The block SHALL have parameter N_OBS, default 4: number of obstacle slots.
REQ-002 The block SHALL have parameter OBS_SIZE, default 32: obstacle square side in pixels.
REQ-003 The block SHALL have parameters PLAYER_W and PLAYER_H, default 32 each: player box size in pixels.
REQ-004 The block SHALL have parameter SPAWN_PERIOD, default 60: frame ticks between spawn attempts.
REQ-005 The block SHALL have parameter STEP, default 2: pixels fallen per frame tick.
REQ-006 The block SHALL have parameters SCREEN_W and SCREEN_H, defaults 640 and 480.
REQ-007 The block SHALL have parameter LFSR_SEED, default 10'h2A5, non-zero.
REQ-008 The block SHALL have port CLOCK_50, input, 1 bit: 50 MHz system clock.
REQ-009 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the CLOCK_50 rising edge.
REQ-010 The block SHALL have port start, input, 1 bit: start key, active-low.
REQ-011 The block SHALL have port vsync, input, 1 bit: VGA vertical sync, active-low, asynchronous to the block.
REQ-012 The block SHALL have ports next_x and next_y, input, 10 bits each: the pixel the VGA stage will draw next.
REQ-013 The block SHALL have ports player_x and player_y, input, 10 bits each: player box top-left corner.
REQ-014 The block SHALL have port obstacle_drawing, output, 1 bit: (next_x, next_y) lies inside an active obstacle.
REQ-015 The block SHALL have port game_over, output, 1 bit: high when not in PLAY.
REQ-016 The block SHALL have ports score and max_score, output, 7 bits each: current score and best score.

Function
REQ-017 vsync SHALL pass through a 2-flop synchronizer.
REQ-018 frame_tick SHALL be a one-cycle pulse on each falling edge of the synchronized vsync.
REQ-019 FSM states SHALL be IDLE, PLAY and OVER.
REQ-020 FSM transitions SHALL be: IDLE->PLAY when start==0; PLAY->OVER on collision; OVER->IDLE when start==1.
REQ-021 On the cycle of entering PLAY, all slots SHALL be cleared, score SHALL be set to 0 and the spawn timer SHALL be set to 0.
REQ-022 The 10-bit Fibonacci LFSR (taps x^10+x^7+1) SHALL advance every cycle in all states.
REQ-023 spawn_x SHALL be lfsr if lfsr<608, otherwise lfsr-608, giving a range of 0..607.
REQ-024 On each frame_tick in PLAY, the spawn timer SHALL increment.
REQ-025 When the spawn timer reaches SPAWN_PERIOD-1, it SHALL return to 0 and the lowest-indexed free slot SHALL become active at (spawn_x, 0).
REQ-026 If no slot is free at a spawn attempt, the spawn SHALL be skipped and the timer SHALL still reset.
REQ-027 On each frame_tick in PLAY, every active slot that was not spawned on that tick SHALL have y += STEP, computed 11 bits wide.
REQ-028 A slot whose new y is >= SCREEN_H SHALL become inactive, and score SHALL increment by 1, saturating at 127.
REQ-029 If several slots exit on the same tick, score SHALL add the count of exiting slots, saturating at 127.
REQ-030 max_score SHALL be updated to score whenever score > max_score, on the cycle after score changes.
REQ-031 max_score SHALL be cleared only by reset.
REQ-032 Collision SHALL be evaluated every cycle in PLAY using 11-bit arithmetic: active slot with obs_x < player_x+PLAYER_W and player_x < obs_x+OBS_SIZE and obs_y < player_y+PLAYER_H and player_y < obs_y+OBS_SIZE.
REQ-033 Collision SHALL move the FSM to OVER on the next edge.
REQ-034 In OVER, slot positions, score and spawn timer SHALL be frozen.
REQ-035 obstacle_drawing SHALL be registered with 1-cycle latency from next_x/next_y.
REQ-036 obstacle_drawing SHALL be high when the pixel is inside any active slot box in PLAY or OVER, and 0 in IDLE.
REQ-037 Pixels at coordinates x >= SCREEN_W or y >= SCREEN_H SHALL never assert obstacle_drawing.

Reset
REQ-038 On reset: state SHALL be IDLE, all slots inactive, score=0, max_score=0, spawn timer=0, lfsr=LFSR_SEED, obstacle_drawing=0, game_over=1, synchronizer flops=1.
REQ-039 Reset SHALL take priority over every other event, including mid-PLAY, a simultaneous frame_tick, and a simultaneous collision.

Verification
REQ-040 Reset, start=1 for 100 cycles -> game_over=1, score=0, max_score=0, obstacle_drawing=0 for any next_x/next_y.
REQ-041 Press start, player at (0,448), 60 vsync falls -> slot0 active at (model spawn_x, 0); obstacle_drawing=1 one cycle after next_x=spawn_x+5, next_y=3; 0 at next_y=40.
REQ-042 Continue with player away from slot0's column -> slot0 exits 240 ticks after spawn; score=1 and max_score=1 on the following cycle.
REQ-043 Player placed at (spawn_x, 448) -> at the tick y becomes 418, game_over=1 next cycle; y stays 418; score unchanged after 10 more ticks.
REQ-044 SPAWN_PERIOD=10, N_OBS=4 -> 4 slots fill by tick 40; tick-50 spawn skipped; first free slot reused once an exit occurs.
REQ-045 Reset asserted mid-PLAY with score=5 and max_score=5 -> next cycle score=0, max_score=0, all slots inactive, game_over=1.
